// File: rtl/key_voice_pkg.sv
// Shared constants, parser state, event payload and note tables for the
// polyphonic key-to-voice allocator.
package key_voice_pkg;

    localparam logic [7:0]  SC_BREAK  = 8'hF0;
    localparam logic [7:0]  SC_EXT    = 8'hE0;
    localparam int unsigned NOTE_W    = 5;
    localparam int unsigned NUM_NOTES = 22;
    localparam int unsigned TABLE_M_W = 16;
    localparam logic [NOTE_W-1:0] NOTE_NONE = 5'd31;

    typedef enum logic [1:0] {IDLE, BRK, EXT, EXTBRK} parse_state_e;

    typedef struct packed {
        logic              valid;
        logic              brk;
        logic [NOTE_W-1:0] note;
    } key_evt_t;

    localparam logic [TABLE_M_W-1:0] TABLE_M [NUM_NOTES] = '{
        16'd389,  16'd412,  16'd436,  16'd462,  16'd490,  16'd519,
        16'd550,  16'd583,  16'd617,  16'd654,  16'd693,  16'd734,
        16'd778,  16'd824,  16'd873,  16'd925,  16'd980,  16'd1038,
        16'd1100, 16'd1165, 16'd1234, 16'd1308
    };

    function automatic logic [NOTE_W-1:0] scancode_to_note(input logic [7:0] code);
        case (code)
            8'h0D: return 5'd0;
            8'h16: return 5'd1;
            8'h15: return 5'd2;
            8'h1E: return 5'd3;
            8'h1D: return 5'd4;
            8'h24: return 5'd5;
            8'h25: return 5'd6;
            8'h2D: return 5'd7;
            8'h2E: return 5'd8;
            8'h2C: return 5'd9;
            8'h36: return 5'd10;
            8'h35: return 5'd11;
            8'h3C: return 5'd12;
            8'h3E: return 5'd13;
            8'h43: return 5'd14;
            8'h46: return 5'd15;
            8'h44: return 5'd16;
            8'h4D: return 5'd17;
            8'h4E: return 5'd18;
            8'h54: return 5'd19;
            8'h55: return 5'd20;
            8'h5B: return 5'd21;
            default: return NOTE_NONE;
        endcase
    endfunction

    // Constant-index scan keeps out-of-range notes (e.g. NOTE_NONE) at zero.
    function automatic logic [TABLE_M_W-1:0] note_to_m(input logic [NOTE_W-1:0] note);
        logic [TABLE_M_W-1:0] m;
        m = '0;
        for (int i = 0; i < int'(NUM_NOTES); i++) begin
            if (note == NOTE_W'(i)) m = TABLE_M[i];
        end
        return m;
    endfunction

endpackage

// File: rtl/ps2_make_break_parser.sv
// PS/2 Set-2 prefix tracker: turns the scancode byte stream into registered
// make/break note events (stage 1); extended and unmapped keys are dropped.
module ps2_make_break_parser
    import key_voice_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] data,
    input  logic       data_valid,
    output key_evt_t   evt
);

    parse_state_e      state, state_nxt;
    key_evt_t          evt_nxt;
    logic              is_make, is_break;
    logic [NOTE_W-1:0] note_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            evt   <= '0;
        end else if (!enable) begin
            state <= IDLE;
            evt   <= '0;
        end else begin
            state <= state_nxt;
            evt   <= evt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        is_make   = 1'b0;
        is_break  = 1'b0;
        if (data_valid) begin
            case (state)
                IDLE: begin
                    if (data == SC_BREAK)    state_nxt = BRK;
                    else if (data == SC_EXT) state_nxt = EXT;
                    else                     is_make   = 1'b1;
                end
                BRK: begin
                    is_break  = 1'b1;
                    state_nxt = IDLE;
                end
                EXT:     state_nxt = (data == SC_BREAK) ? EXTBRK : IDLE;
                EXTBRK:  state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
        note_c        = scancode_to_note(data);
        evt_nxt.valid = (is_make || is_break) && (note_c != NOTE_NONE);
        evt_nxt.brk   = is_break;
        evt_nxt.note  = note_c;
    end

endmodule

// File: rtl/key_voice_allocator.sv
// Polyphonic voice allocator: parsed key events claim, release or steal voice
// slots; each active voice emits an octave-shifted phase increment.
module key_voice_allocator
    import key_voice_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned M_WIDTH    = 16,
    parameter int unsigned NOTE_BITS  = 5
) (
    input  logic                          Clock,
    input  logic                          Reset_n,
    input  logic                          Enable,
    input  logic [7:0]                    KeyboardData,
    input  logic                          DataValid,
    input  logic [1:0]                    Octave,
    output logic [NUM_VOICES*M_WIDTH-1:0] VoiceM,
    output logic [NUM_VOICES-1:0]         VoiceActive,
    output logic                          KeyEvent
);

    localparam int unsigned PTR_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [NOTE_BITS-1:0] VNOTE_NONE = NOTE_BITS'(NOTE_NONE);

    key_evt_t                      evt;
    logic [NOTE_BITS-1:0]          voice_note [NUM_VOICES];
    logic [PTR_W-1:0]              steal_ptr;
    logic [NOTE_BITS-1:0]          evt_note;
    logic                          hit, has_free;
    logic [PTR_W-1:0]              hit_idx, free_idx, alloc_idx;
    logic [NUM_VOICES*M_WIDTH-1:0] m_nxt;
    logic [M_WIDTH-1:0]            base;

    ps2_make_break_parser u_parser (
        .clk        (Clock),
        .rst_n      (Reset_n),
        .enable     (Enable),
        .data       (KeyboardData),
        .data_valid (DataValid),
        .evt        (evt)
    );

    // Stage 2 lookup: voice already holding the note, and lowest free voice.
    always_comb begin
        evt_note = NOTE_BITS'(evt.note);
        hit      = 1'b0;
        hit_idx  = '0;
        has_free = 1'b0;
        free_idx = '0;
        for (int v = 0; v < int'(NUM_VOICES); v++) begin
            if (VoiceActive[v] && (voice_note[v] == evt_note)) begin
                hit     = 1'b1;
                hit_idx = PTR_W'(v);
            end
        end
        for (int v = int'(NUM_VOICES) - 1; v >= 0; v--) begin
            if (!VoiceActive[v]) begin
                has_free = 1'b1;
                free_idx = PTR_W'(v);
            end
        end
        alloc_idx = has_free ? free_idx : steal_ptr;
    end

    // Stage 2: in-place voice table update so consecutive events see each other.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int v = 0; v < int'(NUM_VOICES); v++) voice_note[v] <= VNOTE_NONE;
            VoiceActive <= '0;
            steal_ptr   <= '0;
            KeyEvent    <= 1'b0;
        end else if (!Enable) begin
            for (int v = 0; v < int'(NUM_VOICES); v++) voice_note[v] <= VNOTE_NONE;
            VoiceActive <= '0;
            steal_ptr   <= '0;
            KeyEvent    <= 1'b0;
        end else begin
            KeyEvent <= 1'b0;
            if (evt.valid && !evt.brk && !hit) begin
                voice_note[alloc_idx]  <= evt_note;
                VoiceActive[alloc_idx] <= 1'b1;
                KeyEvent               <= 1'b1;
                if (!has_free) begin
                    steal_ptr <= (steal_ptr == PTR_W'(NUM_VOICES - 1)) ? '0
                                                                      : steal_ptr + PTR_W'(1);
                end
            end else if (evt.valid && evt.brk && hit) begin
                voice_note[hit_idx]  <= VNOTE_NONE;
                VoiceActive[hit_idx] <= 1'b0;
                KeyEvent             <= 1'b1;
            end
        end
    end

    // Stage 3: table lookup with signed octave shift, recomputed every cycle.
    always_comb begin
        m_nxt = '0;
        base  = '0;
        for (int v = 0; v < int'(NUM_VOICES); v++) begin
            base = M_WIDTH'(note_to_m(NOTE_W'(voice_note[v])));
            if (VoiceActive[v]) begin
                case (Octave)
                    2'b01:   m_nxt[v*M_WIDTH +: M_WIDTH] = base << 1;
                    2'b00:   m_nxt[v*M_WIDTH +: M_WIDTH] = base;
                    2'b11:   m_nxt[v*M_WIDTH +: M_WIDTH] = base >> 1;
                    default: m_nxt[v*M_WIDTH +: M_WIDTH] = base >> 2;
                endcase
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n)     VoiceM <= '0;
        else if (!Enable) VoiceM <= '0;
        else              VoiceM <= m_nxt;
    end

endmodule

// File: tb/tb_key_voice_allocator.sv
// Scoreboard bench for key_voice_allocator: a behavioural keyboard/voice
// model predicts each KeyEvent; a monitor pops and checks on every pulse.
module tb_key_voice_allocator;

    localparam int NV = 4;
    localparam int MW = 16;

    logic              Clock = 1'b0;
    logic              Reset_n = 1'b0;
    logic              Enable = 1'b1;
    logic [7:0]        KeyboardData = 8'h00;
    logic              DataValid = 1'b0;
    logic [1:0]        Octave = 2'b00;
    logic [NV*MW-1:0]  VoiceM;
    logic [NV-1:0]     VoiceActive;
    logic              KeyEvent;

    key_voice_allocator #(.NUM_VOICES(NV), .M_WIDTH(MW), .NOTE_BITS(5)) dut (
        .Clock        (Clock),
        .Reset_n      (Reset_n),
        .Enable       (Enable),
        .KeyboardData (KeyboardData),
        .DataValid    (DataValid),
        .Octave       (Octave),
        .VoiceM       (VoiceM),
        .VoiceActive  (VoiceActive),
        .KeyEvent     (KeyEvent)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    typedef struct {
        int               due;
        logic [NV-1:0]    mask;
        logic [NV*MW-1:0] m;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    logic [7:0] codes [22] = '{8'h0D, 8'h16, 8'h15, 8'h1E, 8'h1D, 8'h24, 8'h25, 8'h2D,
                               8'h2E, 8'h2C, 8'h36, 8'h35, 8'h3C, 8'h3E, 8'h43, 8'h46,
                               8'h44, 8'h4D, 8'h4E, 8'h54, 8'h55, 8'h5B};
    int mvals [22] = '{389, 412, 436, 462, 490, 519, 550, 583, 617, 654, 693, 734,
                       778, 824, 873, 925, 980, 1038, 1100, 1165, 1234, 1308};

    // Model state: which note each voice holds (-1 = free), steal slot, prefixes.
    int m_note [NV];
    int m_ptr;
    bit p_brk, p_ext;
    int oct_i = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    function automatic int lookup(input logic [7:0] b);
        for (int i = 0; i < 22; i++) if (codes[i] == b) return i;
        return -1;
    endfunction

    function automatic logic [MW-1:0] shifted(input int n);
        int b;
        b = mvals[n];
        case (oct_i)
            1:       return MW'(b * 2);
            0:       return MW'(b);
            -1:      return MW'(b / 2);
            default: return MW'(b / 4);
        endcase
    endfunction

    function automatic logic [NV*MW-1:0] model_m();
        logic [NV*MW-1:0] r;
        r = '0;
        for (int v = 0; v < NV; v++) if (m_note[v] >= 0) r[v*MW +: MW] = shifted(m_note[v]);
        return r;
    endfunction

    function automatic logic [NV-1:0] model_mask();
        logic [NV-1:0] r;
        r = '0;
        for (int v = 0; v < NV; v++) r[v] = (m_note[v] >= 0);
        return r;
    endfunction

    function automatic void model_clear();
        for (int v = 0; v < NV; v++) m_note[v] = -1;
        m_ptr = 0;
        p_brk = 1'b0;
        p_ext = 1'b0;
    endfunction

    // Returns 1 when the byte produces a visible voice change.
    function automatic bit model_step(input logic [7:0] b);
        int  n, slot;
        bit  was_brk, was_ext;
        if (b == 8'hF0 && !p_brk) begin p_brk = 1'b1; return 1'b0; end
        if (b == 8'hE0 && !p_brk && !p_ext) begin p_ext = 1'b1; return 1'b0; end
        was_brk = p_brk;
        was_ext = p_ext;
        p_brk = 1'b0;
        p_ext = 1'b0;
        if (was_ext) return 1'b0;
        n = lookup(b);
        if (n < 0) return 1'b0;
        slot = -1;
        for (int v = 0; v < NV; v++) if (m_note[v] == n) slot = v;
        if (was_brk) begin
            if (slot < 0) return 1'b0;
            m_note[slot] = -1;
            return 1'b1;
        end
        if (slot >= 0) return 1'b0;
        for (int v = 0; v < NV; v++) if (m_note[v] < 0 && slot < 0) slot = v;
        if (slot < 0) begin
            slot  = m_ptr;
            m_ptr = (m_ptr + 1) % NV;
        end
        m_note[slot] = n;
        return 1'b1;
    endfunction

    task automatic send(input logic [7:0] b);
        @(negedge Clock);
        KeyboardData = b;
        DataValid    = 1'b1;
        if (model_step(b)) sb.push_back('{cyc + 2, model_mask(), model_m()});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge Clock);
            DataValid = 1'b0;
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_active"}, 64'(VoiceActive), 64'd0);
        chk({name, "_m"}, 64'(VoiceM), 64'd0);
        chk({name, "_event"}, 64'(KeyEvent), 64'd0);
    endtask

    task automatic clear_by_enable();
        @(negedge Clock);
        Enable    = 1'b0;
        DataValid = 1'b0;
        @(negedge Clock);
        chk_zero("enable_clear");
        Enable = 1'b1;
        model_clear();
    endtask

    task automatic set_oct(input int o);
        @(negedge Clock);
        Octave = 2'(o);
        oct_i  = o;
        @(negedge Clock);
    endtask

    // Monitor: every KeyEvent must match the next predicted event.
    bit               mon_pend = 1'b0;
    logic [NV*MW-1:0] mon_m;
    always @(negedge Clock) begin : monitor
        exp_t e;
        if (mon_pend) begin
            chk("voice_m_after_event", 64'(VoiceM), 64'(mon_m));
            mon_pend = 1'b0;
        end
        if (KeyEvent === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_key_event", 64'(KeyEvent), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("event_cycle", 64'(cyc), 64'(e.due));
                chk("event_active", 64'(VoiceActive), 64'(e.mask));
                mon_m    = e.m;
                mon_pend = 1'b1;
            end
        end
    end

    initial begin : stim
        logic [7:0] b;
        int         r;
        model_clear();
        repeat (2) @(negedge Clock);
        chk_zero("reset");
        Reset_n = 1'b1;

        // Single key lands in voice 0.
        send(8'h0D);
        idle(4);
        chk("single_active", 64'(VoiceActive), 64'b0001);
        chk("single_m0", 64'(VoiceM[15:0]), 64'd389);
        chk("single_others", 64'(VoiceM[63:16]), 64'd0);

        // Fill all voices, then steal voices 0 and 1.
        send(8'h16); send(8'h15); send(8'h1E);
        send(8'h1D); send(8'h24);
        idle(4);
        chk("steal_m0", 64'(VoiceM[15:0]), 64'd490);
        chk("steal_m1", 64'(VoiceM[31:16]), 64'd519);
        chk("steal_m2", 64'(VoiceM[47:32]), 64'd436);
        chk("steal_m3", 64'(VoiceM[63:48]), 64'd462);

        // Typematic repeat, then release.
        clear_by_enable();
        send(8'h0D); idle(3);
        send(8'h0D); idle(4);
        chk("repeat_m0", 64'(VoiceM[15:0]), 64'd389);
        send(8'hF0); send(8'h0D);
        idle(4);
        chk("release_active", 64'(VoiceActive), 64'd0);
        chk("release_m", 64'(VoiceM), 64'd0);

        // Extended and unmapped codes do nothing.
        send(8'h0D); idle(3);
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        send(8'h1C);
        idle(4);
        chk("ext_active", 64'(VoiceActive), 64'b0001);
        chk("ext_m0", 64'(VoiceM[15:0]), 64'd389);

        // Octave shift on the highest note.
        clear_by_enable();
        send(8'h5B); idle(4);
        chk("oct0", 64'(VoiceM[15:0]), 64'd1308);
        set_oct(1);  chk("oct_p1", 64'(VoiceM[15:0]), 64'd2616);
        set_oct(-1); chk("oct_m1", 64'(VoiceM[15:0]), 64'd654);
        set_oct(-2); chk("oct_m2", 64'(VoiceM[15:0]), 64'd327);
        set_oct(0);  chk("oct_back", 64'(VoiceM[15:0]), 64'd1308);

        // Enable drop mid-pipeline, with a strobe during the low cycle.
        clear_by_enable();
        send(8'h0D); send(8'h16); idle(4);
        chk("two_keys", 64'(VoiceActive), 64'b0011);
        @(negedge Clock);
        KeyboardData = 8'h15; DataValid = 1'b1;
        @(negedge Clock);
        Enable = 1'b0; KeyboardData = 8'h1E; DataValid = 1'b1;
        @(negedge Clock);
        chk_zero("flush_enable");
        Enable = 1'b1; DataValid = 1'b0;
        model_clear();
        idle(4);
        chk_zero("flush_enable_after");

        // Asynchronous reset mid-pipeline.
        send(8'h0D); send(8'h16); idle(4);
        @(negedge Clock);
        KeyboardData = 8'h15; DataValid = 1'b1;
        @(posedge Clock);
        #2 Reset_n = 1'b0; DataValid = 1'b0;
        #1 chk_zero("async_reset");
        @(negedge Clock);
        Reset_n = 1'b1;
        model_clear();
        idle(4);
        chk_zero("async_reset_after");

        // Random traffic on a small key pool to force repeats, breaks and steals.
        for (int round = 0; round < 4; round++) begin
            idle(4);
            set_oct($urandom_range(0, 3) - 2);
            for (int i = 0; i < 150; i++) begin
                r = $urandom_range(0, 99);
                if (r < 65)      b = codes[$urandom_range(0, 6)];
                else if (r < 80) b = 8'hF0;
                else if (r < 87) b = 8'hE0;
                else if (r < 93) b = codes[$urandom_range(0, 21)];
                else             b = 8'($urandom);
                send(b);
                if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
            end
            idle(6);
            chk("round_active", 64'(VoiceActive), 64'(model_mask()));
            chk("round_m", 64'(VoiceM), 64'(model_m()));
        end

        idle(6);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
